// File: rtl/match_pkg.sv
// Shared types and encodings for the match score keeper.
package match_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } match_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_BLUE = 2'b01;
  localparam logic [1:0] WIN_RED  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/match_score_keeper_if.sv
// Bundle between the match score keeper, the ball controller, input front end and HUD.
interface match_score_keeper_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               start_btn;
  logic               blue_score_up;
  logic               red_score_up;
  logic               game_initiated;
  logic               game_over;
  logic [SCORE_W-1:0] blue_score;
  logic [SCORE_W-1:0] red_score;
  logic [1:0]         winner;
  logic               serving;

  modport master (
    output start_btn, blue_score_up, red_score_up,
    input  game_initiated, game_over, blue_score, red_score, winner, serving
  );

  modport slave (
    input  start_btn, blue_score_up, red_score_up,
    output game_initiated, game_over, blue_score, red_score, winner, serving
  );
endinterface

// File: rtl/match_start_conditioner.sv
// Start button conditioning: optional 2-flop synchroniser (MATCH_START_SYNC_EN) and rising-edge pulse.
module match_start_conditioner (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start_btn,
  output logic o_start_pulse
);
  logic w_start_lvl;
  logic r_start_prev;

`ifdef MATCH_START_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_start_btn};
  end

  assign w_start_lvl = r_sync[1];
`else
  assign w_start_lvl = i_start_btn;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_start_prev <= 1'b0;
    else        r_start_prev <= w_start_lvl;
  end

  // Combinational so the FSM reacts on the first cycle the level is seen.
  assign o_start_pulse = w_start_lvl & ~r_start_prev;
endmodule

// File: rtl/match_score_keeper.sv
// Match-level FSM: serves, counts goals from ball-controller toggles, declares the winner.
// Optional start synchroniser selected by MATCH_START_SYNC_EN (see match_start_conditioner).
module match_score_keeper
  import match_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned SERVE_DELAY = 50_000_000,
  parameter int unsigned SCORE_W     = 4
) (
  input logic                clk,
  input logic                rst_n,
  match_score_keeper_if.slave bus
);
  localparam int unsigned        CNT_W     = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);

  match_state_t       r_state;
  logic [CNT_W-1:0]   r_serve_cnt;
  logic               r_prev_blue;
  logic               r_prev_red;
  logic [SCORE_W-1:0] r_blue_score;
  logic [SCORE_W-1:0] r_red_score;
  logic [1:0]         r_winner;
  logic               r_game_over;
  logic               r_game_init;
  logic               r_serving;

  logic               w_start_pulse;
  logic               w_blue_goal;
  logic               w_red_goal;
  logic [SCORE_W-1:0] w_blue_next;
  logic [SCORE_W-1:0] w_red_next;
  logic               w_blue_win;
  logic               w_red_win;

  match_start_conditioner u_start (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start_btn  (bus.start_btn),
    .o_start_pulse(w_start_pulse)
  );

  assign w_blue_goal = bus.blue_score_up ^ r_prev_blue;
  assign w_red_goal  = bus.red_score_up ^ r_prev_red;
  assign w_blue_next = r_blue_score + SCORE_W'(w_blue_goal);
  assign w_red_next  = r_red_score + SCORE_W'(w_red_goal);
  assign w_blue_win  = (w_blue_next == SCORE_WIN);
  assign w_red_win   = (w_red_next == SCORE_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_serve_cnt  <= '0;
      r_prev_blue  <= 1'b0;
      r_prev_red   <= 1'b0;
      r_blue_score <= '0;
      r_red_score  <= '0;
      r_winner     <= WIN_NONE;
      r_game_over  <= 1'b1;
      r_game_init  <= 1'b0;
      r_serving    <= 1'b0;
    end else begin
      // Toggles are tracked in every state so stale flips never count later.
      r_prev_blue <= bus.blue_score_up;
      r_prev_red  <= bus.red_score_up;
      r_game_init <= 1'b0;
      unique case (r_state)
        ST_IDLE, ST_OVER: begin
          if (w_start_pulse) begin
            r_state      <= ST_SERVE;
            r_serve_cnt  <= '0;
            r_blue_score <= '0;
            r_red_score  <= '0;
            r_winner     <= WIN_NONE;
            r_game_over  <= 1'b0;
            r_serving    <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (r_serve_cnt == CNT_LAST) begin
            r_state     <= ST_PLAY;
            r_serve_cnt <= '0;
            r_game_init <= 1'b1;
            r_serving   <= 1'b0;
          end else begin
            r_serve_cnt <= r_serve_cnt + 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_blue_goal || w_red_goal) begin
            r_blue_score <= w_blue_next;
            r_red_score  <= w_red_next;
            if (w_blue_win || w_red_win) begin
              r_state     <= ST_OVER;
              r_game_over <= 1'b1;
              if (w_blue_win && w_red_win) r_winner <= WIN_DRAW;
              else if (w_blue_win)         r_winner <= WIN_BLUE;
              else                         r_winner <= WIN_RED;
            end else begin
              r_state     <= ST_SERVE;
              r_serve_cnt <= '0;
              r_serving   <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.game_initiated = r_game_init;
  assign bus.game_over      = r_game_over;
  assign bus.blue_score     = r_blue_score;
  assign bus.red_score      = r_red_score;
  assign bus.winner         = r_winner;
  assign bus.serving        = r_serving;
endmodule

// File: tb/tb_match_score_keeper.sv
// Randomised bench for match_score_keeper against a goal-level match model (WIN_SCORE=3, SERVE_DELAY=4).
module tb_match_score_keeper;
  localparam int unsigned WIN = 3;
  localparam int unsigned SD  = 4;
  localparam int unsigned SW  = 4;
`ifdef MATCH_START_SYNC_EN
  localparam int unsigned START_LAT = 3;
`else
  localparam int unsigned START_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  match_score_keeper_if #(.SCORE_W(SW)) bus ();

  match_score_keeper #(
    .WIN_SCORE  (WIN),
    .SERVE_DELAY(SD),
    .SCORE_W    (SW)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  int m_blue = 0;
  int m_red  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_winner();
    if (m_blue >= WIN && m_red >= WIN) return 2'b11;
    if (m_blue >= WIN)                 return 2'b01;
    if (m_red >= WIN)                  return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_scores(input string tag);
    check_eq({tag, "_blue"}, 32'(bus.blue_score), 32'(m_blue));
    check_eq({tag, "_red"}, 32'(bus.red_score), 32'(m_red));
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_game_over"}, 32'(bus.game_over), 32'd1);
    check_eq({tag, "_game_init"}, 32'(bus.game_initiated), 32'd0);
    check_eq({tag, "_serving"}, 32'(bus.serving), 32'd0);
    check_eq({tag, "_blue"}, 32'(bus.blue_score), 32'd0);
    check_eq({tag, "_red"}, 32'(bus.red_score), 32'd0);
    check_eq({tag, "_winner"}, 32'(bus.winner), 32'd0);
  endtask

  task automatic start_match();
    bus.start_btn = 1'b1;
    for (int unsigned i = 1; i <= START_LAT; i++) begin
      tick();
      if (i < START_LAT) check_eq("start_early_serving", 32'(bus.serving), 32'd0);
    end
    bus.start_btn = 1'b0;
    m_blue = 0;
    m_red  = 0;
    check_eq("start_serving", 32'(bus.serving), 32'd1);
    check_eq("start_game_over", 32'(bus.game_over), 32'd0);
    check_eq("start_winner", 32'(bus.winner), 32'd0);
    check_scores("start_clear");
  endtask

  // Called on the first SERVE cycle; returns on the game_initiated cycle.
  task automatic wait_serve();
    int unsigned srv = 1;
    int unsigned cyc = 0;
    bit poke_start = ($urandom_range(0, 1) == 1);
    case ($urandom_range(0, 3))
      1: bus.blue_score_up = ~bus.blue_score_up;
      2: bus.red_score_up  = ~bus.red_score_up;
      3: begin
        bus.blue_score_up = ~bus.blue_score_up;
        bus.red_score_up  = ~bus.red_score_up;
      end
      default: ;
    endcase
    if (poke_start) bus.start_btn = 1'b1;
    while (bus.game_initiated !== 1'b1 && cyc < 20) begin
      tick();
      bus.start_btn = 1'b0;
      cyc++;
      if (bus.serving === 1'b1) srv++;
    end
    check_eq("serve_delay", cyc, SD);
    check_eq("serving_len", srv, SD);
    check_eq("serving_fall", 32'(bus.serving), 32'd0);
    check_eq("serve_game_over", 32'(bus.game_over), 32'd0);
    check_scores("serve_ignored_goal");
  endtask

  // Called on the game_initiated cycle; applies goal code g (1 blue, 2 red, 3 both).
  task automatic play_goal(input int g, output bit over);
    int unsigned idle = $urandom_range(0, 3);
    for (int unsigned i = 0; i < idle; i++) begin
      if (i == 0 && idle == 3 && $urandom_range(0, 1) == 1) bus.start_btn = 1'b1;
      tick();
      bus.start_btn = 1'b0;
      check_eq("play_pulse_once", 32'(bus.game_initiated), 32'd0);
      check_eq("play_serving", 32'(bus.serving), 32'd0);
      check_eq("play_game_over", 32'(bus.game_over), 32'd0);
      check_scores("play_idle");
    end
    if (g & 1) bus.blue_score_up = ~bus.blue_score_up;
    if (g & 2) bus.red_score_up  = ~bus.red_score_up;
    tick();
    if (g & 1) m_blue++;
    if (g & 2) m_red++;
    over = (model_winner() != 2'b00);
    check_scores("goal");
    check_eq("goal_winner", 32'(bus.winner), 32'(model_winner()));
    check_eq("goal_game_over", 32'(bus.game_over), 32'(over));
    check_eq("goal_serving", 32'(bus.serving), 32'(!over));
    check_eq("goal_pulse", 32'(bus.game_initiated), 32'd0);
  endtask

  function automatic int pick_goal(input int kind, input int idx);
    int draw_seq[5] = '{1, 2, 1, 2, 3};
    int win31_seq[4] = '{1, 2, 1, 1};
    case (kind)
      0:       return 1;
      1:       return draw_seq[idx];
      2:       return win31_seq[idx];
      default: return $urandom_range(1, 3);
    endcase
  endfunction

  task automatic play_match(input int kind);
    bit over = 1'b0;
    int idx = 0;
    start_match();
    while (!over && idx < 10) begin
      wait_serve();
      play_goal(pick_goal(kind, idx), over);
      idx++;
    end
    check_eq("match_ended", 32'(over), 32'd1);
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      check_eq("over_no_serve", 32'(bus.game_initiated), 32'd0);
      check_eq("over_game_over", 32'(bus.game_over), 32'd1);
      check_eq("over_winner_held", 32'(bus.winner), 32'(model_winner()));
      check_scores("over_held");
    end
  endtask

  initial begin
    bit over;
    bus.start_btn     = 1'b0;
    bus.blue_score_up = 1'b0;
    bus.red_score_up  = 1'b0;
    repeat (3) tick();
    check_reset_vals("in_reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check_reset_vals("after_reset");

    play_match(0);
    check_eq("three_blue_winner", 32'(bus.winner), 32'd1);
    play_match(1);
    check_eq("draw_winner", 32'(bus.winner), 32'd3);
    play_match(2);
    check_eq("win31_red", 32'(bus.red_score), 32'd1);
    for (int k = 0; k < 8; k++) play_match(3);

    start_match();
    wait_serve();
    play_goal(1, over);
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      check_eq("reset_no_pulse", 32'(bus.game_initiated), 32'd0);
    end
    rst_n = 1'b1;
    repeat (SD + 2) tick();
    check_reset_vals("reset_idle_hold");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/match_score_keeper.md
# match_score_keeper

Match-level controller directly downstream of the ball controller. Consumes its per-team goal toggles, keeps both scores, and decides when a match ends. Drives the ball controller's `game_initiated` (serve pulse) and `game_over` (hold-dead level) inputs, which closes the loop. Sits between the player-input front end (start button) and the score/HUD renderer.

## Interface
Parameters:
- `WIN_SCORE`, default 5: goals needed to win; must be ≤ 2^`SCORE_W`−1.
- `SERVE_DELAY`, default 50_000_000: cycles from serve entry to the `game_initiated` pulse; must be ≥ 1.
- `SCORE_W`, default 4: score counter width.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start_btn`, in, 1: start/restart request, active-high level.
- `blue_score_up`, in, 1: toggle from the ball controller; each transition is one blue goal.
- `red_score_up`, in, 1: toggle from the ball controller; each transition is one red goal.
- `game_initiated`, out, 1: one-cycle serve pulse to the ball controller.
- `game_over`, out, 1: level; high holds the ball dead.
- `blue_score`, out, `SCORE_W`: blue goal count.
- `red_score`, out, `SCORE_W`: red goal count.
- `winner`, out, 2: match winner; 00 none, 01 blue, 10 red, 11 draw.
- `serving`, out, 1: high while in SERVE, for the HUD.

## Operation
- All outputs are registered.
- **Goal detection:**
  - `prev_blue` and `prev_red` registers sample the toggles every cycle.
  - A goal event is `toggle ^ prev`.
  - Prev registers reset to 0, matching the ball controller's initial toggle value.
- **Start detection:** rising edge of the conditioned `start_btn`.
- **FSM states:**
  - IDLE (reset state): `game_over`=1.
    - Start edge: clear scores and `winner`, go to SERVE.
  - SERVE: `game_over`=0, `serving`=1, serve counter runs.
    - When the counter reaches `SERVE_DELAY`−1: go to PLAY and assert `game_initiated` for exactly one cycle.
  - PLAY: goal event(s) increment the respective score(s).
    - Any score reaching `WIN_SCORE`: go to OVER, set `winner`.
    - Otherwise go to SERVE; the counter restarts at 0.
  - OVER: `game_over`=1; scores and `winner` held.
    - Start edge: clear scores and `winner`, go to SERVE.
- **Simultaneous goals in PLAY:** both scores increment. If both reach `WIN_SCORE` on the same cycle, `winner`=11.
- **Ignored events:**
  - Goal events outside PLAY are ignored, but prev registers still track the toggles.
  - Start edges in SERVE or PLAY are ignored.
- **Score arithmetic:** unsigned, width `SCORE_W`. Scores never exceed `WIN_SCORE`, so there is no wrap.

## Timing
- **Reset values:**
  - `game_over`=1, `game_initiated`=0, `serving`=0.
  - Scores 0, `winner`=00.
  - State IDLE, serve counter 0.
- **Reset mid-operation:** immediate return to the reset values, including during a `game_initiated` pulse.
- **Start latency:** start edge sampled at cycle N gives state=SERVE, `serving`=1 and `game_over`=0 at N+1. Without the sync macro, N is the first cycle `start_btn` is high.
- **Serve latency:** `game_initiated` is high for one cycle, exactly `SERVE_DELAY` cycles after SERVE entry. `serving` falls on that same cycle.
- **Goal latency:**
  - Toggle change at cycle N: score updates at N+1.
  - State becomes SERVE or OVER at N+1.
  - `game_over` rises at N+1 on a win.

## Configuration
- `MATCH_START_SYNC_EN`:
  - Defined: `start_btn` passes through a 2-flop synchroniser before edge detection, adding 2 cycles of start latency.
  - Undefined: `start_btn` is treated as synchronous to `clk` and edge-detected directly.

## Structure
- Package `match_pkg` holds:
  - state enum (IDLE, SERVE, PLAY, OVER);
  - winner encodings (`WIN_NONE`, `WIN_BLUE`, `WIN_RED`, `WIN_DRAW`).
- One sub-module, `match_start_conditioner`:
  - optional synchroniser under `MATCH_START_SYNC_EN`;
  - rising-edge detector producing a one-cycle start pulse.
- Goal toggle detection, the FSM and the serve counter stay in the top module.

## Test plan
All scenarios use `WIN_SCORE`=3 and `SERVE_DELAY`=4.
- Reset then start pulse: `game_over` falls 1 cycle later; `game_initiated` is a single-cycle pulse 4 cycles after SERVE entry; `serving` is high for exactly 4 cycles.
- Three blue toggles in PLAY, each after its serve: `blue_score` goes 1, 2, 3; after the third, `game_over`=1 and `winner`=01, and no further `game_initiated`.
- Both toggles flip on the same cycle with scores at 2-2: both become 3, `winner`=11, state OVER.
- Toggle flipped during SERVE: score unchanged, and no goal is registered when PLAY begins.
- Start edge in OVER at 3-1: scores clear to 0-0, `winner`=00, new serve pulse 4 cycles later.
- Assert `rst_n` low during SERVE: asynchronous return to the reset values with no `game_initiated` pulse. Additionally, with `MATCH_START_SYNC_EN` defined, start latency is measured as 3 cycles.
